// File: rtl/prog_clk_ctrl_if.sv
// Configuration write port of prog_clk_ctrl: valid/ready handshake, target
// channel, new half-period, and the discard pulse for writes to channel 3.
interface prog_clk_ctrl_if #(
    parameter int DIV_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [DIV_W-1:0] cfg_half;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_half,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_half,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/prog_clk_ctrl.sv
// Three independent programmable clock dividers. A new half-period is held
// pending and applied only at a glitch-free boundary (idle, or end of low phase).
module prog_clk_ctrl #(
    parameter int DIV_W = 16,
    parameter int NCH   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    prog_clk_ctrl_if.slave cfg,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] busy
);

    logic [3:0] busy_ext;
    logic       cfg_we;

    // Channel 3 has no storage, so it can always take (and discard) a write.
    assign busy_ext      = 4'(busy);
    assign cfg.cfg_ready = (cfg.cfg_ch == 2'd3) || !busy_ext[cfg.cfg_ch];
    assign cfg_we        = cfg.cfg_valid && cfg.cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_err <= cfg_we && (cfg.cfg_ch == 2'd3);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIV_W-1:0] active_half;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] pend_half;
        logic             pend;
        logic             out;
        logic             running;
        logic             terminal;
        logic             accept;
        logic             apply;

        assign running  = |active_half;
        assign terminal = running && (cnt == active_half - DIV_W'(1));
        assign accept   = cfg_we && (cfg.cfg_ch == 2'(i));
        // Swapping the divisor only while idle or as a low phase ends means the
        // next phase is a full high phase at the new rate: no runt pulses.
        assign apply    = pend && (!running || (terminal && !out));

        // NOTE: every per-channel register, including the pending half-period,
        // is cleared by the async reset so a half-written config cannot survive.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                active_half <= '0;
                cnt         <= '0;
                pend_half   <= '0;
                pend        <= 1'b0;
                out         <= 1'b0;
            end else begin
                // NOTE: non-blocking throughout, so apply/terminal are all
                // evaluated on pre-edge values regardless of statement order.
                if (apply) begin
                    active_half <= pend_half;
                    cnt         <= '0;
                    out         <= |pend_half;
                end else if (running) begin
                    if (terminal) begin
                        cnt <= '0;
                        out <= ~out;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end else begin
                    cnt <= '0;
                    out <= 1'b0;
                end

                // accept requires !pend, apply requires pend: never both at once.
                if (apply) begin
                    pend <= 1'b0;
                end else if (accept) begin
                    pend      <= 1'b1;
                    pend_half <= cfg.cfg_half;
                end
            end
        end

        assign clk_out[i] = out;
        assign busy[i]    = pend;
    end

endmodule

// File: tb/tb_prog_clk_ctrl.sv
// Randomized and directed bench for prog_clk_ctrl against a phase-countdown
// model: each channel tracks its level and the cycles left in the current phase.
module tb_prog_clk_ctrl;
    localparam int DIV_W = 16;
    localparam int NCH   = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] busy;

    prog_clk_ctrl_if #(.DIV_W(DIV_W)) cfg_if ();

    prog_clk_ctrl #(.DIV_W(DIV_W), .NCH(NCH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg     (cfg_if.slave),
        .clk_out (clk_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state per channel.
    int m_half  [NCH];
    int m_rem   [NCH];
    int m_level [NCH];
    int m_pend  [NCH];
    int m_ph    [NCH];
    int m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_half[i] = 0; m_rem[i] = 0; m_level[i] = 0; m_pend[i] = 0; m_ph[i] = 0;
        end
        m_err = 0;
    endtask

    function automatic logic [NCH-1:0] exp_clk();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_level[i] != 0);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_busy();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_pend[i] != 0);
        return v;
    endfunction

    // One clock edge of the reference: a new divisor lands when the channel is
    // idle or its low phase is on its last cycle; otherwise count the phase down.
    task automatic model_step(input bit v, input int ch, input int half);
        bit acc;
        acc = v && (ch == 3 || m_pend[ch] == 0);
        for (int i = 0; i < NCH; i++) begin
            if (m_pend[i] != 0 && (m_half[i] == 0 || (m_rem[i] == 1 && m_level[i] == 0))) begin
                m_half[i]  = m_ph[i];
                m_level[i] = (m_ph[i] != 0) ? 1 : 0;
                m_rem[i]   = m_ph[i];
                m_pend[i]  = 0;
            end else if (m_half[i] != 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_level[i] = 1 - m_level[i];
                    m_rem[i]   = m_half[i];
                end
            end
        end
        if (acc && ch < 3) begin
            m_pend[ch] = 1;
            m_ph[ch]   = half;
        end
        m_err = (acc && ch == 3) ? 1 : 0;
    endtask

    // Offer (or not) a write for one cycle, check ready before the edge and
    // all registered outputs just after it.
    task automatic cycle(input bit v, input int ch, input int half);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_ch    = 2'(ch);
        cfg_if.cfg_half  = DIV_W'(half);
        #1;
        if (v) check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(ch == 3 || m_pend[ch] == 0));
        @(posedge clk);
        model_step(v, ch, half);
        #1;
        check("clk_out", 32'(clk_out), 32'(exp_clk()));
        check("busy", 32'(busy), 32'(exp_busy()));
        check("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 0);
    endtask

    initial begin
        rst_n            = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_half  = '0;
        model_reset();
        #2;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_err", 32'(cfg_if.cfg_err), 32'd0);
        #18 rst_n = 1'b1;
        check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);

        // ch0 half=4: one busy cycle, then 4 high / 4 low.
        cycle(1'b1, 0, 4);
        check("ch0_busy_once", 32'(busy[0]), 32'd1);
        idle(20);

        // ch1 half=3, retuned to 5 while high.
        cycle(1'b1, 1, 3);
        for (int k = 0; k < 20 && !(m_half[1] == 3 && m_level[1] == 1 && m_rem[1] == 2); k++) idle(1);
        cycle(1'b1, 1, 5);
        idle(24);

        // ch2 half=2, then switched off.
        cycle(1'b1, 2, 2);
        idle(5);
        cycle(1'b1, 2, 0);
        idle(8);
        check("ch2_off", 32'(clk_out[2]), 32'd0);

        // Same value rewrite on ch0 must not disturb the waveform.
        cycle(1'b1, 0, 4);
        idle(12);

        // ch0 busy: second ch0 write refused, ch1 write accepted next.
        cycle(1'b1, 0, 10);
        idle(12);
        cycle(1'b1, 0, 2);
        cycle(1'b1, 0, 7);
        cycle(1'b1, 1, 1);
        idle(25);

        // Discarded write to channel 3.
        cycle(1'b1, 3, 9);
        idle(2);

        // Max half-period is a legal write.
        cycle(1'b1, 2, 16'hFFFF);
        idle(4);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            int h;
            h = ($urandom_range(0, 15) == 0) ? 16'hFFFF : int'($urandom_range(0, 6));
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), h);
        end

        // Async reset mid-phase with all channels running and ch1 pending.
        cycle(1'b1, 0, 3);
        cycle(1'b1, 2, 2);
        cycle(1'b1, 1, 4);
        idle(6);
        cycle(1'b1, 1, 6);
        check("pre_rst_busy1", 32'(busy[1]), 32'(m_pend[1]));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_clk_out", 32'(clk_out), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
